// File: rtl/xalu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op encodings,
// default latencies and the single-shot result function.
package xalu_pkg;

    typedef enum logic [2:0] {
        XOP_MULT  = 3'd0,
        XOP_MULTU = 3'd1,
        XOP_DIV   = 3'd2,
        XOP_DIVU  = 3'd3,
        XOP_MTHI  = 3'd4,
        XOP_MTLO  = 3'd5
    } xop_e;

    localparam int XALU_MULT_CYCLES = 5;
    localparam int XALU_DIV_CYCLES  = 10;

    // Returns {hi, lo}. Signed divide works in 33 bits so 0x80000000 / -1
    // yields +2^31, whose low word is 0x80000000 with remainder 0.
    function automatic logic [63:0] xalu_compute(input logic [2:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        logic signed [63:0] w_ma;
        logic signed [63:0] w_mb;
        logic signed [32:0] w_da;
        logic signed [32:0] w_db;
        logic signed [32:0] w_q;
        logic signed [32:0] w_r;
        logic [63:0]        w_res;
        w_ma  = {{32{a[31]}}, a};
        w_mb  = {{32{b[31]}}, b};
        w_da  = {a[31], a};
        w_db  = {b[31], b};
        w_q   = '0;
        w_r   = '0;
        w_res = '0;
        case (op)
            XOP_MULT:  w_res = w_ma * w_mb;
            XOP_MULTU: w_res = {32'd0, a} * {32'd0, b};
            XOP_DIV: begin
                if (b != '0) begin
                    w_q   = w_da / w_db;
                    w_r   = w_da % w_db;
                    w_res = {w_r[31:0], w_q[31:0]};
                end
            end
            XOP_DIVU: begin
                if (b != '0) w_res = {a % b, a / b};
            end
            default: w_res = '0;
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/xalu.sv
// HI/LO multiply-divide unit: the result is computed when the op is accepted
// and held in a pending register until the latency counter expires.
module xalu
    import xalu_pkg::*;
#(
    parameter int MULT_CYCLES = XALU_MULT_CYCLES,
    parameter int DIV_CYCLES  = XALU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        interupt,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] xalu_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic [63:0]   r_pend;
    logic [2:0]    r_op;
    logic [31:0]   r_b;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic          w_busy;
    logic          w_is_div;
    logic          w_start_ok;
    logic          w_wr_ok;
    logic          w_pend_div0;
    logic          w_commit;
    logic [CW-1:0] w_load;

    // Acceptance: start is taken on an edge where start=1, unit idle, no flush
    // and op is a mult/div; wr is taken only when idle, unflushed, start low
    // and op is MTHI/MTLO. Nothing is ever held off -- an unaccepted request
    // is simply dropped, so the pipeline must stall on busy.
    assign w_busy      = (r_cnt != '0);
    assign w_is_div    = (op == XOP_DIV) || (op == XOP_DIVU);
    assign w_start_ok  = start && !w_busy && !interupt && (op <= XOP_DIVU);
    assign w_wr_ok     = wr && !start && !w_busy && !interupt &&
                         ((op == XOP_MTHI) || (op == XOP_MTLO));
    assign w_load      = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    assign w_pend_div0 = ((r_op == XOP_DIV) || (r_op == XOP_DIVU)) && (r_b == '0);
    assign w_commit    = (r_cnt == CW'(1)) && !w_pend_div0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_pend <= '0;
            r_op   <= '0;
            r_b    <= '0;
        end else if (w_start_ok) begin
            r_cnt  <= w_load;
            r_pend <= xalu_compute(op, a, b);
            r_op   <= op;
            r_b    <= b;
        end else if (w_busy) begin
            r_cnt  <= r_cnt - CW'(1);
        end
    end

    // Commit and MTHI/MTLO cannot collide: writes need the unit idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= r_pend[63:32];
            r_lo <= r_pend[31:0];
        end else if (w_wr_ok) begin
            if (op == XOP_MTHI) r_hi <= a;
            else                r_lo <= a;
        end
    end

    assign busy     = w_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign xalu_out = hilo_sel ? r_hi : r_lo;

endmodule
